hilo_mul_ctrl: RTL and testbench

Iterative unsigned multiply controller that owns the HI/LO register pair for the pipelined MIPS core. It sequences MULTU and MADDU as a multi-cycle shift-add operation beside the EX stage. It serves MFHI/MFLO reads and raises a stall to the hazard logic while a multiply is in flight. The core's decode stage drives its request strobes.

---
 rtl/hilo_mul_ctrl.sv | 110 +++++++++++
 tb/tb_hilo_mul_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl
//   Iterative unsigned shift-add multiplier that owns the HI/LO pair for the
//   MIPS core. MULTU overwrites HI/LO with the product; MADDU adds the product
//   into HI/LO (modulo 2^(2*WIDTH)). One multiplier bit is consumed per cycle,
//   then a single write-back cycle commits the result.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, acc        multiply request (accepted in IDLE only); acc=1 -> MADDU
//   src_a, src_b      multiplicand / multiplier, sampled on accept
//   cancel            pipeline flush; aborts an operation still in RUN
//   read_req/sel      MFHI/MFLO read; read_data = sel ? hi : lo
//   hi, lo            architectural HI/LO registers
//   busy              a multiply is in flight (RUN or WB)
//   stall             busy while decode presents start or a read
//   done              one-cycle pulse in the first cycle after HI/LO commit
module hilo_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             read_req,
  input  logic             read_sel,
  output logic [WIDTH-1:0] read_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             acc_q;
  logic [PW-1:0]    prod;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    addend;

  // Partial product for this iteration: multiplicand weighted by the count of
  // multiplier bits already consumed (the multiplier itself shifts right).
  assign addend    = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;

  assign busy      = (state != S_IDLE);
  assign stall     = busy & (start | read_req);
  // In IDLE this is the current HI/LO, so a read paired with an accepted
  // start sees the pre-multiply value.
  assign read_data = read_sel ? hi : lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc_q  <= 1'b0;
      prod   <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // cancel is irrelevant here; a start alongside it is still taken
          if (start) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc_q  <= acc;
            prod   <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            prod   <= prod + addend;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) state <= S_WB;
          end
        end
        S_WB: begin
          // Commit is not cancellable; carry out of HI is dropped.
          if (acc_q) {hi, lo} <= {hi, lo} + prod;
          else       {hi, lo} <= prod;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Self-checking bench for hilo_mul_ctrl. The reference is a 64-bit {hi,lo}
// value updated with plain multiplication/addition per completed operation.
module tb_hilo_mul_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         acc;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         cancel;
  logic         read_req;
  logic         read_sel;
  logic [W-1:0] read_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;

  int           n_assert;
  int           n_fail;
  logic [2*W-1:0] model;

  hilo_mul_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .acc(acc),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .read_req(read_req), .read_sel(read_sel), .read_data(read_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation from an IDLE cycle. cancel_at = busy-cycle index at
  // which cancel is raised (0 = never); indices 1..W fall in RUN, W+1 is WB.
  // A read is issued together with the start to check the pre-multiply value.
  task automatic run_op(input logic acc_i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int cancel_at, input logic cancel_with_start);
    logic [2*W-1:0] prev;
    logic [2*W-1:0] p;
    logic [2*W-1:0] expv;
    logic           sel;
    int             n;
    prev = model;
    p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    expv = acc_i ? prev + p : p;
    sel  = 1'($urandom_range(0, 1));
    start = 1'b1; acc = acc_i; src_a = a; src_b = b;
    cancel = cancel_with_start; read_req = 1'b1; read_sel = sel;
    #1;
    check("idle_read_stall", {63'd0, stall}, 64'd0);
    check("idle_read_data", {32'd0, read_data}, sel ? {32'd0, prev[63:32]} : {32'd0, prev[31:0]});
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; read_req = 1'b0;
    check("accept_busy", {63'd0, busy}, 64'd1);
    check("done_low_after_accept", {63'd0, done}, 64'd0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == cancel_at) cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
    end
    if (cancel_at >= 1 && cancel_at <= W) begin
      check("cancel_busy_len", 64'(n), 64'(cancel_at));
      check("cancel_no_done", {63'd0, done}, 64'd0);
      check("cancel_hilo", {hi, lo}, prev);
    end else begin
      check("busy_len", 64'(n), 64'(W + 1));
      check("done_pulse", {63'd0, done}, 64'd1);
      check("hilo", {hi, lo}, expv);
      model = expv;
    end
  endtask

  initial begin
    int   n;
    int   stall_bad;
    logic seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_assert = 0; n_fail = 0; model = '0;
    rst = 1'b0; start = 1'b0; acc = 1'b0; src_a = '0; src_b = '0;
    cancel = 1'b0; read_req = 1'b0; read_sel = 1'b0;

    // Reset state
    #2 rst = 1'b1; read_req = 1'b1;
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; read_req = 1'b0;
    @(posedge clk); #1;

    // Max operands; done is a single pulse
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("max_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check("max_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
    @(posedge clk); #1;
    check("done_once", {63'd0, done}, 64'd0);

    // MULTU then MADDU, back to back
    run_op(1'b0, 32'd3, 32'd5, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'd4, 0, 1'b0);
    check("maddu_hilo", {hi, lo}, 64'h0000_0002_0000_000F);

    // Wrap-around of the accumulate
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    check("wrap1_hilo", {hi, lo}, 64'hFFFF_FFFF_0000_0000);
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    check("wrap2_hilo", {hi, lo}, 64'd0);

    // Read held from busy cycle 5, start held for the whole operation
    start = 1'b1; acc = 1'b0; src_a = 32'd7; src_b = 32'h4000_0000;
    read_req = 1'b0; read_sel = 1'b1;
    @(posedge clk); #1;
    n = 0; stall_bad = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n >= 5) read_req = 1'b1;
      #1;
      if (stall !== 1'b1) stall_bad++;
      @(posedge clk); #1;
    end
    check("held_busy_len", 64'(n), 64'(W + 1));
    check("held_stall_while_busy", 64'(stall_bad), 64'd0);
    check("held_done", {63'd0, done}, 64'd1);
    check("held_done_stall", {63'd0, stall}, 64'd0);
    check("held_read_data", {32'd0, read_data}, 64'd1);
    model = 64'h0000_0001_C000_0000;
    check("held_hilo", {hi, lo}, model);
    @(posedge clk); #1;
    start = 1'b0; read_req = 1'b0;
    check("held_start_accepted", {63'd0, busy}, 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("held_second_len", 64'(n), 64'(W + 1));
    check("held_second_hilo", {hi, lo}, model);

    // Build HI/LO = 0x12345678/0x9ABCDEF0, then cancel in RUN
    run_op(1'b0, 32'h1234_5678, 32'h8000_0000, 0, 1'b0);
    run_op(1'b1, 32'h1234_5678, 32'h8000_0000, 0, 1'b0);
    run_op(1'b1, 32'h9ABC_DEF0, 32'd1, 0, 1'b0);
    check("preset_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    run_op(1'b0, $urandom, $urandom, 10, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | done;
    end
    check("cancel_never_done", {63'd0, seen}, 64'd0);
    check("cancel_hilo_kept", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

    // Cancel in the last RUN cycle aborts; cancel in WB is ignored
    run_op(1'b1, $urandom, $urandom, W, 1'b0);
    run_op(1'b1, $urandom, $urandom, W + 1, 1'b0);

    // Random mix of MULTU/MADDU, cancel occasionally paired with start in IDLE
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb & 32'h0000_00FF;
      run_op(1'($urandom_range(0, 1)), ra, rb, 0, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset at busy cycle 12
    start = 1'b1; acc = 1'b1; src_a = $urandom; src_b = $urandom;
    @(posedge clk); #1;
    start = 1'b0; read_req = 1'b1;
    repeat (11) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_stall", {63'd0, stall}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; read_req = 1'b0; model = '0;
    @(posedge clk); #1;
    run_op(1'b0, 32'd2, 32'd2, 0, 1'b0);
    check("post_rst_lo", {32'd0, lo}, 64'd4);
    check("post_rst_hi", {32'd0, hi}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
